// File: rtl/spi_cmos_frame_tx.sv
// SPI (mode 0) frame transmitter: buffers words in a small FIFO and sends each one MSB first under cs_n.
// Define SPI_CMOS_TX_PARITY_EN to append an odd-parity bit to every frame.
module spi_cmos_frame_tx #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int SCK_HALF   = 1,
    parameter int GAP_CYCLES = 1
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          cs_n_out,
    output logic                          sck_out,
    output logic                          miso_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
    output logic [15:0]                   frame_cnt
);

`ifdef SPI_CMOS_TX_PARITY_EN
    localparam int FRAME_BITS = DATA_WIDTH + 1;
`else
    localparam int FRAME_BITS = DATA_WIDTH;
`endif

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BIT_W = $clog2(FRAME_BITS + 1);
    localparam int DIV_W = $clog2(SCK_HALF + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_HALF - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    logic [1:0]            state;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      cnt_next;
    logic                  push;
    logic                  pop;
    logic [FRAME_BITS-1:0] load_word;
    logic [FRAME_BITS-1:0] shift_reg;
    logic [BIT_W-1:0]      bit_cnt;
    logic [DIV_W-1:0]      div_cnt;
    logic [GAP_W-1:0]      gap_cnt;

    // Handshake: a word transfers on any rising edge where in_valid and in_ready are both high;
    // in_ready comes from the registered count, so a pop in LOAD frees a slot only from the next cycle.
    assign push = in_valid && in_ready;
    assign pop  = (state == ST_LOAD);

    always_comb begin
        cnt_next = fifo_cnt;
        if (push && !pop) begin
            cnt_next = fifo_cnt + CNT_W'(1);
        end else if (!push && pop) begin
            cnt_next = fifo_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            in_ready <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_cnt <= cnt_next;
            in_ready <= (cnt_next != CNT_FULL);
        end
    end

`ifdef SPI_CMOS_TX_PARITY_EN
    // Trailing bit makes the XOR over payload and parity equal to 1.
    assign load_word = {mem[rd_ptr], ~^mem[rd_ptr]};
`else
    assign load_word = mem[rd_ptr];
`endif

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= ST_IDLE;
            cs_n_out  <= 1'b1;
            sck_out   <= 1'b0;
            miso_out  <= 1'b0;
            busy      <= 1'b0;
            frame_cnt <= '0;
            shift_reg <= '0;
            bit_cnt   <= '0;
            div_cnt   <= '0;
            gap_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fifo_cnt != '0) begin
                        state <= ST_LOAD;
                        busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    shift_reg <= load_word;
                    bit_cnt   <= BIT_LAST;
                    div_cnt   <= '0;
                    cs_n_out  <= 1'b0;
                    sck_out   <= 1'b0;
                    miso_out  <= load_word[FRAME_BITS-1];
                    state     <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    // sck_out itself marks which half of the bit we are in.
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (!sck_out) begin
                            sck_out <= 1'b1;
                        end else begin
                            sck_out <= 1'b0;
                            if (bit_cnt == '0) begin
                                state     <= ST_GAP;
                                cs_n_out  <= 1'b1;
                                miso_out  <= 1'b0;
                                frame_cnt <= frame_cnt + 16'd1;
                                gap_cnt   <= '0;
                            end else begin
                                shift_reg <= {shift_reg[FRAME_BITS-2:0], 1'b0};
                                miso_out  <= shift_reg[FRAME_BITS-2];
                                bit_cnt   <= bit_cnt - BIT_W'(1);
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        if (fifo_cnt != '0) begin
                            state <= ST_LOAD;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    cs_n_out <= 1'b1;
                    sck_out  <= 1'b0;
                    miso_out <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cmos_frame_tx.sv
// Directed bench for spi_cmos_frame_tx: reset, single frame, back-to-back with full FIFO,
// push/pop at full, reset mid-frame, and parity frames when SPI_CMOS_TX_PARITY_EN is defined.
module tb_spi_cmos_frame_tx;

`ifdef SPI_CMOS_TX_PARITY_EN
    localparam int FB = 33;
`else
    localparam int FB = 32;
`endif

    logic        sys_clk;
    logic        sys_rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        cs_n_out;
    logic        sck_out;
    logic        miso_out;
    logic        busy;
    logic [2:0]  fifo_cnt;
    logic [15:0] frame_cnt;

    spi_cmos_frame_tx dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cs_n_out  (cs_n_out),
        .sck_out   (sck_out),
        .miso_out  (miso_out),
        .busy      (busy),
        .fifo_cnt  (fifo_cnt),
        .frame_cnt (frame_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Expected frames (payload plus parity when enabled), oldest first.
    logic [FB-1:0] exp_q[$];

    function automatic logic [FB-1:0] frame_of(input logic [31:0] w);
`ifdef SPI_CMOS_TX_PARITY_EN
        return {w, ~^w};
`else
        return w;
`endif
    endfunction

    // Bus monitor, sampled on the falling sys_clk edge.
    logic          cs_prev = 1'b1;
    logic          sck_prev = 1'b0;
    logic [63:0]   acc = '0;
    logic [FB-1:0] last_frame = '0;
    int            nbits = 0;
    int            low_len = 0;
    int            high_len = 0;
    int            frames_seen = 0;
    int            sck_bad = 0;
    int            gap_q[$];

    always @(negedge sys_clk) begin
        if (sys_rst) begin
            cs_prev  = 1'b1;
            sck_prev = 1'b0;
            nbits    = 0;
            low_len  = 0;
            high_len = 0;
            acc      = '0;
            exp_q.delete();
        end else begin
            if (cs_n_out && sck_out) sck_bad++;
            if (!cs_n_out) begin
                if (cs_prev) begin
                    gap_q.push_back(high_len);
                    nbits   = 0;
                    low_len = 0;
                    acc     = '0;
                end
                low_len++;
                if (sck_out && !sck_prev) begin
                    acc = {acc[62:0], miso_out};
                    nbits++;
                end
            end else begin
                if (!cs_prev) begin
                    frames_seen++;
                    check("frame_bits", 64'(nbits), 64'(FB));
                    check("frame_low_cycles", 64'(low_len), 64'(FB * 2));
                    check("frame_expected", 64'(exp_q.size() != 0), 64'd1);
                    last_frame = acc[FB-1:0];
                    if (exp_q.size() != 0) check("frame_data", 64'(acc[FB-1:0]), 64'(exp_q.pop_front()));
                    high_len = 0;
                end
                high_len++;
            end
            cs_prev  = cs_n_out;
            sck_prev = sck_out;
        end
    end

    task automatic do_reset(input int cycles);
        sys_rst  = 1'b1;
        in_valid = 1'b0;
        repeat (cycles) @(negedge sys_clk);
        sys_rst = 1'b0;
    endtask

    // Leaves in_valid high on return so back-to-back calls push on consecutive edges.
    task automatic push_word(input logic [31:0] w);
        logic ok;
        logic done;
        done     = 1'b0;
        in_data  = w;
        in_valid = 1'b1;
        for (int n = 0; n < 500 && !done; n++) begin
            ok = in_ready;
            @(negedge sys_clk);
            if (ok) done = 1'b1;
        end
        check("push_accepted", 64'(done), 64'd1);
        if (done) exp_q.push_back(frame_of(w));
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n;
        n = 0;
        while (frames_seen < target && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        check("frame_wait", 64'(frames_seen >= target), 64'd1);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (!(cs_n_out && !busy && fifo_cnt == 3'd0) && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        check("idle_wait", 64'(n < budget), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0]  prev_cnt;
        logic        prev_ready;
        logic        prev_cs;
        logic [15:0] prev_fc;
        logic        found;
        int          seen;

        in_data  = '0;
        in_valid = 1'b0;
        @(negedge sys_clk);

        // T1 reset / idle
        do_reset(3);
        check("t1_cs_n", 64'(cs_n_out), 64'd1);
        check("t1_sck", 64'(sck_out), 64'd0);
        check("t1_miso", 64'(miso_out), 64'd0);
        check("t1_in_ready", 64'(in_ready), 64'd1);
        check("t1_fifo_cnt", 64'(fifo_cnt), 64'd0);
        check("t1_frame_cnt", 64'(frame_cnt), 64'd0);
        check("t1_busy", 64'(busy), 64'd0);

        // T2 single frame: accepted at t, LOAD at t+1, cs_n low with MSB at t+2
        push_word(32'h02E5CB94);
        in_valid = 1'b0;
        check("t2_cnt_after_push", 64'(fifo_cnt), 64'd1);
        check("t2_cs_after_push", 64'(cs_n_out), 64'd1);
        check("t2_busy_after_push", 64'(busy), 64'd0);
        @(negedge sys_clk);
        check("t2_busy_load", 64'(busy), 64'd1);
        check("t2_cs_load", 64'(cs_n_out), 64'd1);
        @(negedge sys_clk);
        check("t2_cs_shift", 64'(cs_n_out), 64'd0);
        check("t2_sck_first", 64'(sck_out), 64'd0);
        check("t2_cnt_popped", 64'(fifo_cnt), 64'd0);
        wait_frames(1, 200);
        check("t2_payload", 64'(last_frame[FB-1 -: 32]), 64'h02E5CB94);
        check("t2_frame_cnt", 64'(frame_cnt), 64'd1);
        repeat (3) @(negedge sys_clk);
        check("t2_busy_done", 64'(busy), 64'd0);

`ifdef SPI_CMOS_TX_PARITY_EN
        // T6 parity: 0x02E5CB94 has 14 ones -> parity 1; zero word -> parity 1
        seen = frames_seen;
        push_word(32'h02E5CB94);
        in_valid = 1'b0;
        wait_frames(seen + 1, 200);
        check("t6_parity_a", 64'(last_frame[0]), 64'd1);
        push_word(32'h00000000);
        in_valid = 1'b0;
        wait_frames(seen + 2, 200);
        check("t6_parity_b", 64'(last_frame[0]), 64'd1);
        check("t6_payload_b", 64'(last_frame[32:1]), 64'h0);
        wait_idle(50);
`endif

        // T3 back-to-back pushes until full
        do_reset(2);
        gap_q.delete();
        push_word(32'h02E5CB94);
        push_word(32'h12A5A394);
        push_word(32'hFFFFFFFF);
        push_word(32'h00000001);
        push_word(32'h80000000);
        check("t3_full_cnt", 64'(fifo_cnt), 64'd4);
        check("t3_full_ready", 64'(in_ready), 64'd0);
        check("t3_in_flight", 64'(cs_n_out), 64'd0);

        // T4 hold a sixth word while full; it goes in the cycle after LOAD pops
        in_data    = 32'hA5C3_0F18;
        prev_cnt   = fifo_cnt;
        prev_ready = in_ready;
        prev_cs    = cs_n_out;
        prev_fc    = frame_cnt;
        found      = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge sys_clk);
            if (in_ready) begin
                found = 1'b1;
                break;
            end
            prev_cnt   = fifo_cnt;
            prev_ready = in_ready;
            prev_cs    = cs_n_out;
            prev_fc    = frame_cnt;
        end
        check("t4_ready_return", 64'(found), 64'd1);
        check("t4_cnt_at_load", 64'(prev_cnt), 64'd4);
        check("t4_ready_at_load", 64'(prev_ready), 64'd0);
        check("t4_cs_at_load", 64'(prev_cs), 64'd1);
        check("t4_frames_at_load", 64'(prev_fc), 64'd1);
        check("t4_cnt_after_pop", 64'(fifo_cnt), 64'd3);
        exp_q.push_back(frame_of(32'hA5C3_0F18));
        @(negedge sys_clk);
        in_valid = 1'b0;
        check("t4_cnt_refilled", 64'(fifo_cnt), 64'd4);
        check("t4_ready_refilled", 64'(in_ready), 64'd0);
        wait_idle(1500);
        check("t4_frame_cnt", 64'(frame_cnt), 64'd6);
        check("t4_exp_drained", 64'(exp_q.size()), 64'd0);
        check("t3_gap_count", 64'(gap_q.size()), 64'd6);
        for (int i = 1; i < 6; i++) begin
            if (i < gap_q.size()) check($sformatf("t3_gap_%0d", i), 64'(gap_q[i]), 64'd2);
        end

        // T5 reset at bit 10 with three words queued
        push_word(32'h0F0F0F0F);
        push_word(32'h11111111);
        push_word(32'h22222222);
        push_word(32'h33333333);
        in_valid = 1'b0;
        for (int n = 0; n < 200 && nbits < 10; n++) @(negedge sys_clk);
        check("t5_reached_bit10", 64'(nbits), 64'd10);
        check("t5_queued", 64'(fifo_cnt), 64'd3);
        seen    = frames_seen;
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check("t5_cs_n", 64'(cs_n_out), 64'd1);
        check("t5_sck", 64'(sck_out), 64'd0);
        check("t5_fifo_cnt", 64'(fifo_cnt), 64'd0);
        check("t5_frame_cnt", 64'(frame_cnt), 64'd0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (150) @(negedge sys_clk);
        check("t5_no_frames", 64'(frames_seen), 64'(seen));
        check("t5_idle_cs", 64'(cs_n_out), 64'd1);
        check("t5_idle_busy", 64'(busy), 64'd0);
        check("t5_idle_cnt", 64'(frame_cnt), 64'd0);

        check("sck_low_when_cs_high", 64'(sck_bad), 64'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
